// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that gives one port at a time the shared_mem access path.
// It uses registered one-hot read/write grants and a hold quantum that forces a
// handover when another port is waiting.
module mem_port_arbiter #(
  parameter int PORT_COUNT = 4,
  parameter int MAX_HOLD   = 8,
  parameter int SEL_W      = $clog2(PORT_COUNT)
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic [PORT_COUNT-1:0] i_req_rd,
  input  logic [PORT_COUNT-1:0] i_req_wr,
  output logic [PORT_COUNT-1:0] o_grant_rd,
  output logic [PORT_COUNT-1:0] o_grant_wr,
  output logic [SEL_W-1:0]      o_sel,
  output logic                  o_sel_vld,
  output logic                  o_mem_we,
  output logic                  o_preempt
);

  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, GRANT_WR, GRANT_RD} state_t;

  state_t                state, state_n;
  logic [SEL_W-1:0]      sel, sel_n;
  logic [SEL_W-1:0]      ptr, ptr_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic                  preempt, preempt_n;

  logic [PORT_COUNT-1:0] any_req, sel_oh, others, mask;
  logic [SEL_W-1:0]      start, idx, win;
  logic                  held, do_arb, found;

  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] i);
    if (int'(i) == PORT_COUNT - 1) return '0;
    return i + SEL_W'(1);
  endfunction

  assign any_req = i_req_rd | i_req_wr;
  assign sel_oh  = {{(PORT_COUNT-1){1'b0}}, 1'b1} << sel;
  assign others  = any_req & ~sel_oh;
  assign held    = ((state == GRANT_WR) && i_req_wr[sel]) ||
                   ((state == GRANT_RD) && i_req_rd[sel]);

  always_comb begin
    state_n   = state;
    sel_n     = sel;
    ptr_n     = ptr;
    cnt_n     = cnt;
    preempt_n = 1'b0;
    do_arb    = 1'b0;
    mask      = any_req;
    start     = ptr;
    found     = 1'b0;
    win       = '0;
    idx       = '0;

    if (state == IDLE || !held) begin
      do_arb = 1'b1;
    end else if (cnt == CNT_MAX && |others) begin
      // Quantum expired with someone waiting: hand over, skipping the holder.
      do_arb    = 1'b1;
      mask      = others;
      start     = next_idx(sel);
      preempt_n = 1'b1;
    end else if (cnt != CNT_MAX) begin
      cnt_n = cnt + CNT_W'(1);
    end

    for (int i = 0; i < PORT_COUNT; i++) begin
      idx = SEL_W'((int'(start) + i) % PORT_COUNT);
      if (!found && mask[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end

    if (do_arb) begin
      cnt_n = '0;
      if (found) begin
        state_n = i_req_wr[win] ? GRANT_WR : GRANT_RD;
        sel_n   = win;
        ptr_n   = next_idx(win);
      end else begin
        state_n   = IDLE;
        sel_n     = '0;
        preempt_n = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state   <= IDLE;
      sel     <= '0;
      ptr     <= '0;
      cnt     <= '0;
      preempt <= 1'b0;
    end else begin
      state   <= state_n;
      sel     <= sel_n;
      ptr     <= ptr_n;
      cnt     <= cnt_n;
      preempt <= preempt_n;
    end
  end

  assign o_grant_wr = (state == GRANT_WR) ? sel_oh : '0;
  assign o_grant_rd = (state == GRANT_RD) ? sel_oh : '0;
  assign o_sel      = sel;
  assign o_sel_vld  = (state != IDLE);
  assign o_mem_we   = (state == GRANT_WR);
  assign o_preempt  = preempt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single-edge vectors, followed
// by hand-written sequences for quantum preemption and solo hold.
module tb_mem_port_arbiter;
  localparam int PORT_COUNT = 4;
  localparam int MAX_HOLD   = 8;
  localparam int SEL_W      = 2;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic [PORT_COUNT-1:0] req_rd, req_wr;
  logic [PORT_COUNT-1:0] grant_rd, grant_wr;
  logic [SEL_W-1:0]      sel;
  logic                  sel_vld, mem_we, preempt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.PORT_COUNT(PORT_COUNT), .MAX_HOLD(MAX_HOLD), .SEL_W(SEL_W)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_req_rd(req_rd), .i_req_wr(req_wr),
    .o_grant_rd(grant_rd), .o_grant_wr(grant_wr), .o_sel(sel),
    .o_sel_vld(sel_vld), .o_mem_we(mem_we), .o_preempt(preempt)
  );

  typedef struct {
    logic       rstn;
    logic [3:0] rd;
    logic [3:0] wr;
    logic [3:0] exp_rd;
    logic [3:0] exp_wr;
    logic [1:0] exp_sel;
    logic       exp_pre;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [3:0] rd, logic [3:0] wr,
                              logic [3:0] erd, logic [3:0] ewr, logic [1:0] es, logic ep);
    vec_t v;
    v.rstn = r; v.rd = rd; v.wr = wr;
    v.exp_rd = erd; v.exp_wr = ewr; v.exp_sel = es; v.exp_pre = ep;
    return v;
  endfunction

  task automatic apply_stimulus(input logic r, input logic [3:0] rd, input logic [3:0] wr);
    rstn   = r;
    req_rd = rd;
    req_wr = wr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_output(input string tag, input logic [3:0] erd, input logic [3:0] ewr,
                              input logic [1:0] es, input logic ep);
    check_val({tag, " grant_rd"}, {4'h0, grant_rd}, {4'h0, erd});
    check_val({tag, " grant_wr"}, {4'h0, grant_wr}, {4'h0, ewr});
    check_val({tag, " sel"}, {6'h0, sel}, {6'h0, es});
    check_val({tag, " sel_vld"}, {7'h0, sel_vld}, {7'h0, |(erd | ewr)});
    check_val({tag, " mem_we"}, {7'h0, mem_we}, {7'h0, |ewr});
    check_val({tag, " preempt"}, {7'h0, preempt}, {7'h0, ep});
  endtask

  initial begin
    rstn   = 1'b0;
    req_rd = '0;
    req_wr = '0;

    // reset held with all writes pending, then first grant to port 0
    vecs.push_back(mk(0, 4'h0, 4'hF, 4'h0, 4'h0, 2'd0, 0));
    vecs.push_back(mk(0, 4'h0, 4'hF, 4'h0, 4'h0, 2'd0, 0));
    vecs.push_back(mk(1, 4'h0, 4'hF, 4'h0, 4'h1, 2'd0, 0));
    // sequential release, no dead cycles
    vecs.push_back(mk(1, 4'h0, 4'hE, 4'h0, 4'h2, 2'd1, 0));
    vecs.push_back(mk(1, 4'h0, 4'hC, 4'h0, 4'h4, 2'd2, 0));
    vecs.push_back(mk(1, 4'h0, 4'h8, 4'h0, 4'h8, 2'd3, 0));
    vecs.push_back(mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 0));
    // round-robin between ports 0 and 2
    vecs.push_back(mk(1, 4'h5, 4'h0, 4'h1, 4'h0, 2'd0, 0));
    vecs.push_back(mk(1, 4'h4, 4'h0, 4'h4, 4'h0, 2'd2, 0));
    vecs.push_back(mk(1, 4'h1, 4'h0, 4'h1, 4'h0, 2'd0, 0));
    vecs.push_back(mk(1, 4'h4, 4'h0, 4'h4, 4'h0, 2'd2, 0));
    vecs.push_back(mk(1, 4'h1, 4'h0, 4'h1, 4'h0, 2'd0, 0));
    vecs.push_back(mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 0));
    vecs.push_back(mk(1, 4'h5, 4'h0, 4'h4, 4'h0, 2'd2, 0));
    vecs.push_back(mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 0));
    // same port with rd+wr: write first, read re-arbitrated afterwards
    vecs.push_back(mk(1, 4'h4, 4'h4, 4'h0, 4'h4, 2'd2, 0));
    vecs.push_back(mk(1, 4'h4, 4'h0, 4'h4, 4'h0, 2'd2, 0));
    vecs.push_back(mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 0));
    // mid-grant reset clears the pointer
    vecs.push_back(mk(1, 4'h0, 4'h2, 4'h0, 4'h2, 2'd1, 0));
    vecs.push_back(mk(0, 4'h0, 4'h2, 4'h0, 4'h0, 2'd0, 0));
    vecs.push_back(mk(1, 4'h0, 4'h6, 4'h0, 4'h2, 2'd1, 0));
    vecs.push_back(mk(1, 4'h0, 4'h6, 4'h0, 4'h2, 2'd1, 0));
    vecs.push_back(mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].rstn, vecs[i].rd, vecs[i].wr);
      check_output($sformatf("vec%0d", i), vecs[i].exp_rd, vecs[i].exp_wr,
                   vecs[i].exp_sel, vecs[i].exp_pre);
    end

    // quantum preemption: port 1 writes, port 3 starts reading after two grant cycles
    apply_stimulus(1, 4'h0, 4'h2);
    check_output("q_hold1", 4'h0, 4'h2, 2'd1, 0);
    apply_stimulus(1, 4'h0, 4'h2);
    check_output("q_hold2", 4'h0, 4'h2, 2'd1, 0);
    for (int k = 3; k <= MAX_HOLD; k++) begin
      apply_stimulus(1, 4'h8, 4'h2);
      check_output($sformatf("q_hold%0d", k), 4'h0, 4'h2, 2'd1, 0);
    end
    apply_stimulus(1, 4'h8, 4'h2);
    check_output("q_preempt", 4'h8, 4'h0, 2'd3, 1);
    apply_stimulus(1, 4'h8, 4'h2);
    check_output("q_after", 4'h8, 4'h0, 2'd3, 0);
    apply_stimulus(1, 4'h0, 4'h2);
    check_output("q_regain", 4'h0, 4'h2, 2'd1, 0);
    apply_stimulus(1, 4'h0, 4'h0);
    check_output("q_idle", 4'h0, 4'h0, 2'd0, 0);

    // solo holder keeps the grant well past the quantum
    apply_stimulus(1, 4'h0, 4'h4);
    check_output("solo_grant", 4'h0, 4'h4, 2'd2, 0);
    for (int k = 0; k < 20; k++) begin
      apply_stimulus(1, 4'h0, 4'h4);
      check_output($sformatf("solo%0d", k), 4'h0, 4'h4, 2'd2, 0);
    end
    apply_stimulus(1, 4'h0, 4'h0);
    check_output("solo_idle", 4'h0, 4'h0, 2'd0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
